// File: rtl/ad5681_pkg.sv
// Shared definitions for the AD5681 serial path: command codes, command-word
// layout and the frame sequencer state encoding.
package ad5681_pkg;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_WRITE_INPUT  = 4'b0001;
  localparam logic [3:0] CMD_UPDATE       = 4'b0010;

  localparam int WORD_BITS = 24;
  localparam int CMD_MSB   = 23;
  localparam int CMD_LSB   = 20;
  localparam int DATA_MSB  = 19;
  localparam int CODE_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_LDAC,
    ST_RELEASE,
    ST_GAP
  } seq_state_t;

  // code is MSB-aligned in 16 bits; narrower DACs leave the low bits zero
  function automatic logic [WORD_BITS-1:0] fmt_word(input logic [3:0] cmd,
                                                    input logic [CODE_BITS-1:0] code);
    logic [WORD_BITS-1:0] word;
    word = '0;
    word[CMD_MSB:CMD_LSB] = cmd;
    word[DATA_MSB -: CODE_BITS] = code;
    return word;
  endfunction

endpackage

// File: rtl/ad5681_rate_tick.sv
// Sample-rate pacer: free-running 0..RATE_DIV-1 counter, single-cycle tick on
// the last count. Held at zero while disabled.
module ad5681_rate_tick #(
  parameter int RATE_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(RATE_DIV);
  localparam logic [CW-1:0] LAST = CW'(RATE_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_count <= '0;
    else if (!en)             r_count <= '0;
    else if (r_count == LAST) r_count <= '0;
    else                      r_count <= r_count + CW'(1);
  end

  assign tick = en & (r_count == LAST);

endmodule

// File: rtl/ad5681_frame_sequencer.sv
// Paces DAC samples into AD5681 command words and runs the driver's level
// start handshake, using LDAC as the completion feedback.
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   ST_IDLE      | waiting for a rate tick; consumes the held sample
//   ST_START     | first cycle of o_start, clears the timeout counter
//   ST_WAIT_LDAC | o_start held until LDAC goes low or timeout expires
//   ST_RELEASE   | o_start dropped, waiting for the driver to raise LDAC
//   ST_GAP       | GAP idle cycles before the next frame may begin
module ad5681_frame_sequencer
  import ad5681_pkg::*;
#(
  parameter int DAC_BITS = 12,
  parameter int RATE_DIV = 100,
  parameter int TIMEOUT  = 63,
  parameter int GAP      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DAC_BITS-1:0] s_data,
  output logic [23:0]         o_data,
  output logic                o_start,
  input  logic                i_ldac_n,
  output logic                o_busy,
  output logic                o_underrun,
  output logic                o_overrun,
  output logic                o_timeout
);

  localparam int unsigned PAD = CODE_BITS - DAC_BITS;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  seq_state_t r_state, w_next;

  logic                w_tick;
  logic                r_hold_valid;
  logic [DAC_BITS-1:0] r_hold_data;
  logic [23:0]         r_data;
  logic [7:0]          r_cnt;
  logic                w_consume;
  logic                w_cnt_clr;
  logic                w_cnt_inc;
  logic [15:0]         w_code;

  ad5681_rate_tick #(.RATE_DIV(RATE_DIV)) u_rate (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (w_tick)
  );

  assign s_ready = ~r_hold_valid;
  assign w_code  = 16'(r_hold_data) << PAD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_consume) begin
      r_hold_valid <= 1'b0;
    end else if (s_valid && !r_hold_valid) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_data <= '0;
    else if (w_consume) r_data <= fmt_word(CMD_WRITE_UPDATE, w_code);
  end

  // shared by the LDAC timeout and the post-frame gap; never both at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_cnt <= '0;
    else if (w_cnt_clr) r_cnt <= '0;
    else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_consume  = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    o_start    = 1'b0;
    o_underrun = 1'b0;
    o_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          if (r_hold_valid) begin
            w_consume = 1'b1;
            w_next    = ST_START;
          end else begin
            o_underrun = 1'b1;
          end
        end
      end
      ST_START: begin
        o_start   = 1'b1;
        w_cnt_clr = 1'b1;
        w_next    = ST_WAIT_LDAC;
      end
      ST_WAIT_LDAC: begin
        o_start = 1'b1;
        if (!i_ldac_n) begin
          w_next = ST_RELEASE;
        end else if (r_cnt == TO_LAST) begin
          o_timeout = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = ST_GAP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (i_ldac_n) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) w_next = ST_IDLE;
        else                   w_cnt_inc = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // a tick mid-frame is dropped; the held sample waits for the next one
  assign o_overrun = w_tick & (r_state != ST_IDLE);
  assign o_busy    = (r_state != ST_IDLE);
  assign o_data    = r_data;

endmodule

// File: tb/tb_ad5681_frame_sequencer.sv
// Directed bench for ad5681_frame_sequencer: a default instance plus a
// RATE_DIV=40 instance whose driver model answers slower than the period.
module tb_ad5681_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en2;
  logic        s_valid, s_valid2;
  logic        s_ready, s_ready2;
  logic [11:0] s_data, s_data2;
  logic [23:0] o_data, o_data2;
  logic        o_start, o_start2;
  logic        ldac_n = 1'b1;
  logic        ldac_n2 = 1'b1;
  logic        o_busy, o_busy2;
  logic        o_underrun, o_underrun2;
  logic        o_overrun, o_overrun2;
  logic        o_timeout, o_timeout2;

  int n_checks = 0;
  int n_fail   = 0;

  logic ldac_stuck = 1'b0;
  int   ldac_delay = 30;
  int   drv_cnt = 0;
  int   drv_cnt2 = 0;

  always #5 clk = ~clk;

  ad5681_frame_sequencer u_dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .o_data(o_data), .o_start(o_start), .i_ldac_n(ldac_n),
    .o_busy(o_busy), .o_underrun(o_underrun), .o_overrun(o_overrun),
    .o_timeout(o_timeout)
  );

  ad5681_frame_sequencer #(.RATE_DIV(40)) u_ovr (
    .clk(clk), .rst(rst), .en(en2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_data(s_data2), .o_data(o_data2), .o_start(o_start2), .i_ldac_n(ldac_n2),
    .o_busy(o_busy2), .o_underrun(o_underrun2), .o_overrun(o_overrun2),
    .o_timeout(o_timeout2)
  );

  // driver models: LDAC falls after a fixed number of start cycles, rises once start drops
  always @(negedge clk) begin
    if (o_start && !ldac_stuck) begin
      if (ldac_n) begin
        drv_cnt <= drv_cnt + 1;
        if (drv_cnt + 1 == ldac_delay) ldac_n <= 1'b0;
      end
    end else begin
      drv_cnt <= 0;
      if (!o_start) ldac_n <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (o_start2) begin
      if (ldac_n2) begin
        drv_cnt2 <= drv_cnt2 + 1;
        if (drv_cnt2 + 1 == 50) ldac_n2 <= 1'b0;
      end
    end else begin
      drv_cnt2 <= 0;
      ldac_n2  <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] d);
    int n;
    n = 0;
    while (!s_ready && n < 200) begin
      step();
      n++;
    end
    check_eq("push_ready", 32'(s_ready), 1);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] smp [4];
    logic [23:0] wrd [4];
    int   rise_t[$];
    logic [23:0] rise_d[$];
    int   pos[$];
    int   n, m, idx, ucnt, ocnt, tcnt, u2, t2;
    logic prev;

    smp[0] = 12'h001; smp[1] = 12'h800; smp[2] = 12'hFFF; smp[3] = 12'h123;
    wrd[0] = 24'h300100; wrd[1] = 24'h380000; wrd[2] = 24'h3FFF00; wrd[3] = 24'h312300;

    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    s_valid = 1'b0; s_data = '0; s_valid2 = 1'b0; s_data2 = '0;
    repeat (3) step();

    check_eq("rst_o_data",   32'(o_data), 0);
    check_eq("rst_o_start",  32'(o_start), 0);
    check_eq("rst_o_busy",   32'(o_busy), 0);
    check_eq("rst_underrun", 32'(o_underrun), 0);
    check_eq("rst_overrun",  32'(o_overrun), 0);
    check_eq("rst_timeout",  32'(o_timeout), 0);
    check_eq("rst_s_ready",  32'(s_ready), 1);
    check_eq("rst_busy2",    32'(o_busy2), 0);
    rst = 1'b0;
    step();

    // single sample
    push(12'hABC);
    check_eq("t1_hold_full", 32'(s_ready), 0);
    en = 1'b1;
    repeat (99) step();
    check_eq("t1_pre_start", 32'(o_start), 0);
    check_eq("t1_pre_data",  32'(o_data), 0);
    step();
    check_eq("t1_start",     32'(o_start), 1);
    check_eq("t1_data",      32'(o_data), 32'h3ABC00);
    check_eq("t1_consumed",  32'(s_ready), 1);
    n = 0;
    while (o_start && n < 100) begin n++; step(); end
    check_eq("t1_start_len", n, 30);
    m = 0;
    while (o_busy && m < 20) begin m++; step(); end
    check_eq("t1_busy_tail", m, 3);
    en = 1'b0;
    step();

    // stream of four samples
    push(smp[0]);
    en = 1'b1;
    idx = 1; ucnt = 0; ocnt = 0; prev = 1'b0;
    for (int k = 1; k <= 440; k++) begin
      step();
      if (o_start && !prev) begin rise_t.push_back(k); rise_d.push_back(o_data); end
      prev = o_start;
      if (o_underrun) ucnt++;
      if (o_overrun)  ocnt++;
      if (s_valid) s_valid = 1'b0;
      else if (idx < 4 && s_ready) begin
        s_valid = 1'b1; s_data = smp[idx]; idx++;
      end
    end
    en = 1'b0;
    check_eq("t2_frames", rise_t.size(), 4);
    check_eq("t2_underrun", ucnt, 0);
    check_eq("t2_overrun", ocnt, 0);
    if (rise_t.size() == 4) begin
      check_eq("t2_first_rise", rise_t[0], 100);
      for (int i = 1; i < 4; i++) check_eq("t2_spacing", rise_t[i] - rise_t[i-1], 100);
      for (int i = 0; i < 4; i++) check_eq("t2_word", 32'(rise_d[i]), 32'(wrd[i]));
    end
    step();

    // underrun for three periods
    en = 1'b1;
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (o_underrun) pos.push_back(k);
      if (o_start) n++;
    end
    en = 1'b0;
    check_eq("t3_underruns", pos.size(), 3);
    check_eq("t3_no_start", n, 0);
    if (pos.size() == 3)
      for (int i = 0; i < 3; i++) check_eq("t3_pos", pos[i], 99 + 100 * i);
    step();

    // LDAC never answers
    ldac_stuck = 1'b1;
    push(12'h5A5);
    en = 1'b1;
    repeat (100) step();
    check_eq("t4_start", 32'(o_start), 1);
    check_eq("t4_data",  32'(o_data), 32'h35A500);
    n = 0; tcnt = 0;
    while (o_start && n < 200) begin
      n++;
      if (o_timeout) tcnt++;
      step();
    end
    check_eq("t4_start_len", n, 64);
    check_eq("t4_timeouts", tcnt, 1);
    m = 0;
    while (o_busy && m < 20) begin m++; step(); end
    check_eq("t4_gap", m, 2);
    en = 1'b0;
    ldac_stuck = 1'b0;
    step();

    // overrun on the RATE_DIV=40 instance
    s_valid2 = 1'b1; s_data2 = 12'h111;
    step();
    s_valid2 = 1'b0;
    en2 = 1'b1;
    rise_t.delete(); rise_d.delete(); pos.delete();
    idx = 0; prev = 1'b0; u2 = 0; t2 = 0;
    for (int k = 1; k <= 130; k++) begin
      step();
      if (o_start2 && !prev) begin rise_t.push_back(k); rise_d.push_back(o_data2); end
      prev = o_start2;
      if (o_overrun2)  pos.push_back(k);
      if (o_underrun2) u2++;
      if (o_timeout2)  t2++;
      if (k == 79) check_eq("t5_held", 32'(s_ready2), 0);
      if (s_valid2) s_valid2 = 1'b0;
      else if (idx == 0 && s_ready2) begin
        s_valid2 = 1'b1; s_data2 = 12'h222; idx = 1;
      end
    end
    check_eq("t5_busy_end", 32'(o_busy2), 1);
    en2 = 1'b0;
    check_eq("t5_overruns", pos.size(), 1);
    check_eq("t5_underrun", u2, 0);
    check_eq("t5_timeout", t2, 0);
    check_eq("t5_frames", rise_t.size(), 2);
    if (pos.size() == 1) check_eq("t5_ovr_pos", pos[0], 79);
    if (rise_t.size() == 2) begin
      check_eq("t5_rise0", rise_t[0], 40);
      check_eq("t5_rise1", rise_t[1], 120);
      check_eq("t5_word0", 32'(rise_d[0]), 32'h311100);
      check_eq("t5_word1", 32'(rise_d[1]), 32'h322200);
    end
    step();

    // asynchronous reset during WAIT_LDAC
    push(12'h777);
    en = 1'b1;
    repeat (100) step();
    check_eq("t6_start", 32'(o_start), 1);
    s_valid = 1'b1; s_data = 12'h0F0;
    step();
    s_valid = 1'b0;
    check_eq("t6_hold_full", 32'(s_ready), 0);
    repeat (3) step();
    check_eq("t6_in_wait", 32'(o_start), 1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_start", 32'(o_start), 0);
    check_eq("t6_rst_ready", 32'(s_ready), 1);
    check_eq("t6_rst_busy",  32'(o_busy), 0);
    step();
    rst = 1'b0;
    pos.delete();
    n = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (o_underrun) pos.push_back(k);
      if (o_start) n++;
    end
    en = 1'b0;
    check_eq("t6_underruns", pos.size(), 1);
    check_eq("t6_no_start", n, 0);
    if (pos.size() == 1) check_eq("t6_ur_pos", pos[0], 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
